// File: rtl/key_scan_unit.sv
// N-channel push-button front end: two-flop synchroniser, debounce, and per-key
// press/repeat/release pulse generation. All outputs are registered.
module key_scan_unit #(
  parameter int               N_KEYS          = 5,
  parameter int               DEBOUNCE_CYCLES = 400000,
  parameter int               REPEAT_DELAY    = 12000000,
  parameter int               REPEAT_PERIOD   = 4000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK    = N_KEYS'(5'b00011),
  parameter bit               ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  // Terminal values are one below the cycle counts because the registered
  // toggle/pulse lands on the edge after the terminal count is observed.
  localparam logic [DB_W-1:0]  DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_TERM = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_TERM = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [N_KEYS-1:0] key_norm;
  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] sync_2;

  assign key_norm = ACTIVE_LOW ? ~key_in : key_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= key_norm;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             accept;
    logic             allow;
    state_t           state;
    state_t           state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             press_q;
    logic             release_q;

    assign accept = (sync_2[i] != level_q) && (db_cnt == DB_TERM);
    assign allow  = REPEAT_MASK[i] & repeat_en;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync_2[i] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TERM) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // level_q is 0 in IDLE and 1 otherwise, so accept means press in IDLE
    // and release elsewhere; release is checked first so it always wins.
    always_comb begin
      state_nxt   = state;
      rpt_cnt_nxt = rpt_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            press_nxt   = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (accept) begin
            release_nxt = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end else if (rpt_cnt == RD_TERM) begin
            if (allow) begin
              press_nxt   = 1'b1;
              rpt_cnt_nxt = '0;
              state_nxt   = ST_REPEAT;
            end
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (accept) begin
            release_nxt = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end else if (rpt_cnt == RP_TERM) begin
            if (allow) begin
              press_nxt   = 1'b1;
              rpt_cnt_nxt = '0;
            end
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        default: begin
          rpt_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= ST_IDLE;
        rpt_cnt   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        rpt_cnt   <= rpt_cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_scan_unit.sv
// Bench for key_scan_unit: directed timing scenarios plus randomised traffic,
// all compared against a timestamp-based behavioural model.
module tb_key_scan_unit;

  localparam int         N    = 5;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [4:0] MASK = 5'b00011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] pressed;
  logic [4:0] key_in;
  logic       repeat_en;
  logic [4:0] key_level;
  logic [4:0] key_press;
  logic [4:0] key_release;

  assign key_in = ~pressed;

  always #5 clk = ~clk;

  key_scan_unit #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tcur     = 0;

  // Model: raw delay line, consecutive-difference run, and the edge index of
  // the last press pulse from which the next repeat becomes due.
  logic [4:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_release = '0;
  int m_run [N] = '{default: 0};
  int m_last[N] = '{default: 0};
  int m_nrep[N] = '{default: 0};

  function automatic void model_edge();
    logic old;
    tcur++;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_last[i] = 0; m_nrep[i] = 0; end
      return;
    end
    for (int i = 0; i < N; i++) begin
      old = m_level[i];
      m_press[i] = 1'b0;
      m_release[i] = 1'b0;
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_run[i] = 0;
          m_level[i] = ~m_level[i];
        end
      end else begin
        m_run[i] = 0;
      end
      if (!old && m_level[i]) begin
        m_press[i] = 1'b1; m_last[i] = tcur; m_nrep[i] = 0;
      end else if (old && !m_level[i]) begin
        m_release[i] = 1'b1;
      end else if (old && MASK[i] && repeat_en &&
                   tcur >= m_last[i] + ((m_nrep[i] == 0) ? RD : RP)) begin
        m_press[i] = 1'b1; m_last[i] = tcur; m_nrep[i]++;
      end
    end
    m_s2 = m_s1;
    m_s1 = pressed;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pressed = '0; repeat_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pressed = 5'b11111; repeat_en = 1'b1;
    step(); step();
    n_checks++;
    if ({key_level, key_press, key_release} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got lvl=%b prs=%b rel=%b, want all zero", key_level, key_press, key_release);
    end
    pressed = '0;
    step(); step(); step();
    n_checks++;
    if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
      n_fail++;
      $display("FAIL reset_model: got %b/%b/%b want %b/%b/%b", key_level, key_press, key_release, m_level, m_press, m_release);
    end
  endtask

  task automatic test_clean_press();
    int t_press = -1, n_press = 0, t_rel = -1;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      pressed[2] = (c < 20);
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      if (key_press[2]) begin n_press++; if (t_press < 0) t_press = c + 1; end
      if (key_release[2] && t_rel < 0) t_rel = c + 1;
    end
    n_checks++;
    if (t_press !== 6) begin n_fail++; $display("FAIL clean_press_time: got %0d want 6", t_press); end
    n_checks++;
    if (n_press !== 1) begin n_fail++; $display("FAIL clean_press_count: got %0d want 1", n_press); end
    n_checks++;
    if (t_rel !== 26) begin n_fail++; $display("FAIL clean_release_time: got %0d want 26", t_rel); end
  endtask

  task automatic test_glitch();
    logic [14:0] any_out = '0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      pressed[0] = (c < 3);
      step();
      any_out |= {key_level, key_press, key_release};
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
    end
    n_checks++;
    if (any_out !== 15'd0) begin n_fail++; $display("FAIL glitch_quiet: got %b want 0", any_out); end
  endtask

  task automatic test_auto_repeat();
    int q0[$], q2[$], e0[$];
    do_reset();
    for (int c = 0; c < 30; c++) begin
      pressed[0] = 1'b1; pressed[2] = 1'b1;
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL auto_repeat cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      if (key_press[0]) q0.push_back(c + 1);
      if (key_press[2]) q2.push_back(c + 1);
    end
    e0.push_back(6);
    for (int t = 6 + RD; t <= 30; t += RP) e0.push_back(t);
    n_checks++;
    if (q0 != e0) begin n_fail++; $display("FAIL auto_repeat_ch0: got %p want %p", q0, e0); end
    n_checks++;
    if (q2.size() != 1 || q2[0] != 6) begin n_fail++; $display("FAIL no_repeat_ch2: got %p want '{6}", q2); end
  endtask

  task automatic test_repeat_gating();
    int q1[$], e1[$];
    do_reset();
    for (int c = 0; c < 41; c++) begin
      pressed[1] = 1'b1;
      repeat_en = !(c >= 10 && c < 30);
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL repeat_gating cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      if (key_press[1]) q1.push_back(c + 1);
    end
    e1.push_back(6);
    for (int t = 31; t <= 41; t += RP) e1.push_back(t);
    n_checks++;
    if (q1 != e1) begin n_fail++; $display("FAIL repeat_gating_times: got %p want %p", q1, e1); end
    repeat_en = 1'b1;
  endtask

  task automatic test_release_wins();
    logic both_at_6 = 1'b0;
    logic [1:0] at_22 = 2'b00;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      pressed[3] = 1'b1;
      pressed[0] = (c < 16);
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL release_wins cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      if (c + 1 == 6) both_at_6 = key_press[0] & key_press[3];
      if (c + 1 == 22) at_22 = {key_release[0], key_press[0]};
    end
    n_checks++;
    if (both_at_6 !== 1'b1) begin n_fail++; $display("FAIL simultaneous_press: got %b want 1", both_at_6); end
    n_checks++;
    if (at_22 !== 2'b10) begin n_fail++; $display("FAIL release_wins_22: got rel,prs=%b want 10", at_22); end
  endtask

  task automatic test_reset_mid_hold();
    int t_new = -1;
    logic [14:0] at_21 = '1;
    logic [4:0] rel_seen = '0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      pressed[0] = 1'b1;
      rst_n = !(c == 20 || c == 21);
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL reset_mid_hold cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      if (c + 1 == 21) at_21 = {key_level, key_press, key_release};
      if (c + 1 >= 20) rel_seen |= key_release;
      if (c + 1 > 21 && key_press[0] && t_new < 0) t_new = c + 1;
    end
    rst_n = 1'b1;
    n_checks++;
    if (at_21 !== 15'd0) begin n_fail++; $display("FAIL reset_clears: got %b want 0", at_21); end
    n_checks++;
    if (rel_seen !== 5'd0) begin n_fail++; $display("FAIL reset_no_release: got %b want 0", rel_seen); end
    n_checks++;
    if (t_new !== 28) begin n_fail++; $display("FAIL press_after_reset: got %0d want 28", t_new); end
  endtask

  task automatic test_random();
    int hold[N] = '{default: 0};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          pressed[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 30);
        end else begin
          hold[i]--;
        end
      end
      repeat_en = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      n_checks++;
      if ({key_level, key_press, key_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b/%b/%b want %b/%b/%b", c+1, key_level, key_press, key_release, m_level, m_press, m_release);
      end
      n_checks++;
      if ((key_press & key_release) !== 5'd0) begin
        n_fail++;
        $display("FAIL press_release_overlap cyc %0d: got %b want 0", c+1, key_press & key_release);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pressed = '0; repeat_en = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_repeat_gating();
    test_release_wins();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
